// File: rtl/crg_multi.sv
// Multi-domain clock/reset generator. A Wishbone register bank drives glitch-free
// clock gates and per-domain reset sequencers that hold reset for HOLD running cycles.
module crg_multi #(
    parameter int                     NUM_DOMAINS = 4,
    parameter logic [31:0]            BASE_ADDR   = 32'h0200_0400,
    parameter logic [NUM_DOMAINS-1:0] CLK_EN_RST  = '0,
    parameter logic [7:0]             HOLD_RST    = 8'd16
) (
    input  logic                   global_clk,
    input  logic                   global_rst,
    input  logic                   wbm_crg_cyc_i,
    input  logic                   wbm_crg_stb_i,
    input  logic [31:0]            wbm_crg_addr_i,
    input  logic [31:0]            wbm_crg_wdata_i,
    input  logic [3:0]             wbm_crg_sel_i,
    input  logic                   wbm_crg_we_i,
    output logic [31:0]            crg_wbm_rdata_o,
    output logic                   crg_wbm_ack_o,
    output logic [NUM_DOMAINS-1:0] domain_clk_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o
);

    typedef enum logic [1:0] {ST_RST, ST_HOLD, ST_RUN} dom_state_t;

    logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d;
    logic [NUM_DOMAINS-1:0] rst_req_q, rst_req_d;
    logic [7:0]             hold_q, hold_d;
    logic                   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic [NUM_DOMAINS-1:0] in_hold;

    logic [31:0] offset;
    logic [31:0] status_ext;
    logic        in_window;
    logic        req;
    logic        unused_bits;

    assign offset    = wbm_crg_addr_i - BASE_ADDR;
    assign in_window = (offset[31:4] == 28'd0);
    assign req       = wbm_crg_cyc_i & wbm_crg_stb_i & in_window & ~ack_q;

    // Only the low bytes of data/sel reach a register for small NUM_DOMAINS.
    assign unused_bits = ^{wbm_crg_wdata_i, wbm_crg_sel_i};

    always_comb begin
        status_ext                    = '0;
        status_ext[NUM_DOMAINS-1:0]   = dom_rst_q;
        status_ext[16 +: NUM_DOMAINS] = in_hold;
    end

    always_comb begin
        clk_en_d  = clk_en_q;
        rst_req_d = rst_req_q;
        hold_d    = hold_q;
        ack_d     = req;
        rdata_d   = '0;
        if (req) begin
            case (offset[3:0])
                4'h0: begin
                    rdata_d = 32'(clk_en_q);
                    if (wbm_crg_we_i) begin
                        for (int b = 0; b < NUM_DOMAINS; b++) begin
                            if (wbm_crg_sel_i[b/8]) clk_en_d[b] = wbm_crg_wdata_i[b];
                        end
                    end
                end
                4'h4: begin
                    rdata_d = 32'(rst_req_q);
                    if (wbm_crg_we_i) begin
                        for (int b = 0; b < NUM_DOMAINS; b++) begin
                            if (wbm_crg_sel_i[b/8]) rst_req_d[b] = wbm_crg_wdata_i[b];
                        end
                    end
                end
                4'h8: rdata_d = status_ext;
                4'hC: begin
                    rdata_d = {24'd0, hold_q};
                    if (wbm_crg_we_i && wbm_crg_sel_i[0]) hold_d = wbm_crg_wdata_i[7:0];
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge global_clk) begin
        if (global_rst) begin
            clk_en_q  <= CLK_EN_RST;
            rst_req_q <= '1;
            hold_q    <= HOLD_RST;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            dom_rst_q <= '1;
        end else begin
            clk_en_q  <= clk_en_d;
            rst_req_q <= rst_req_d;
            hold_q    <= hold_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            dom_rst_q <= dom_rst_d;
        end
    end

    assign crg_wbm_ack_o   = ack_q;
    assign crg_wbm_rdata_o = rdata_q;
    assign domain_rst_o    = dom_rst_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
            dom_state_t state_q, state_d;
            logic [7:0] cnt_q, cnt_d;
            logic       gate_lat;

            // Enable captured only while the clock is low, so high phases are never cut short.
            always_latch begin
                if (!global_clk) gate_lat <= clk_en_q[gi];
            end
            assign domain_clk_o[gi] = global_clk & gate_lat;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (rst_req_q[gi]) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        ST_RST: begin
                            if (clk_en_q[gi]) begin
                                if (hold_q == 8'd0) begin
                                    state_d = ST_RUN;
                                end else begin
                                    state_d = ST_HOLD;
                                    cnt_d   = hold_q;
                                end
                            end
                        end
                        ST_HOLD: begin
                            // Count only cycles on which the domain clock actually runs.
                            if (clk_en_q[gi]) begin
                                if (cnt_q == 8'd1) begin
                                    state_d = ST_RUN;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q - 8'd1;
                                end
                            end
                        end
                        ST_RUN:  state_d = ST_RUN;
                        default: state_d = ST_RST;
                    endcase
                end
            end

            always_ff @(posedge global_clk) begin
                if (global_rst) begin
                    state_q <= ST_RST;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign dom_rst_d[gi] = (state_d != ST_RUN);
            assign in_hold[gi]   = (state_q == ST_HOLD);
        end
    endgenerate

endmodule

// File: tb/tb_crg_multi.sv
// Randomised and directed bench for crg_multi with a scoreboard fed by a
// cycle-level behavioural model of the register bank and reset release rules.
module tb_crg_multi;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0200_0400;

    logic          global_clk = 1'b0;
    logic          global_rst = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic [3:0]    sel = '0;
    logic [31:0]   rdata;
    logic          ack;
    logic [N-1:0]  dclk, drst;

    crg_multi #(
        .NUM_DOMAINS(N), .BASE_ADDR(BASE), .CLK_EN_RST(4'h0), .HOLD_RST(8'd16)
    ) dut (
        .global_clk(global_clk), .global_rst(global_rst),
        .wbm_crg_cyc_i(cyc), .wbm_crg_stb_i(stb), .wbm_crg_addr_i(addr),
        .wbm_crg_wdata_i(wdata), .wbm_crg_sel_i(sel), .wbm_crg_we_i(we),
        .crg_wbm_rdata_o(rdata), .crg_wbm_ack_o(ack),
        .domain_clk_o(dclk), .domain_rst_o(drst)
    );

    always #5 global_clk = ~global_clk;

    int checks = 0, passes = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural model: a domain leaves reset after HOLD+1 enabled cycles
    // counted from software release; HOLD is sampled on the first of them.
    typedef struct {bit is_rd; logic [31:0] data;} exp_t;
    exp_t         sb[$];
    logic [N-1:0] m_clk_en = '0, m_rst_req = '1, m_rst = '1, exp_dclk_hi = '0;
    logic [7:0]   m_hold = 8'd16;
    bit           m_ack = 0;
    int           m_cnt[N], m_lhold[N];
    longint       cyc_cnt = 0;
    int           ack_total = 0;
    bit           mon_en = 0;

    initial begin
        logic [31:0] off, rd, mask, mrg;
        bit          req;
        exp_t        e;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_lhold[i] = 0; end
        forever begin
            @(posedge global_clk);
            cyc_cnt++;
            exp_dclk_hi = m_clk_en;
            if (global_rst) begin
                m_clk_en = '0; m_rst_req = '1; m_hold = 8'd16; m_ack = 0; m_rst = '1;
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                sb.delete();
            end else begin
                off = addr - BASE;
                req = cyc && stb && (off < 32'd16) && !m_ack;
                if (req) begin
                    rd = '0;
                    case (off)
                        32'h0: rd = 32'(m_clk_en);
                        32'h4: rd = 32'(m_rst_req);
                        32'h8: for (int i = 0; i < N; i++) begin
                                   rd[i]      = m_rst[i];
                                   rd[16 + i] = (m_cnt[i] >= 1) && (m_cnt[i] <= m_lhold[i]);
                               end
                        32'hC: rd = 32'(m_hold);
                        default: rd = '0;
                    endcase
                    e.is_rd = !we; e.data = rd;
                    sb.push_back(e);
                end
                for (int i = 0; i < N; i++) begin
                    if (m_rst_req[i]) m_cnt[i] = 0;
                    else if (m_clk_en[i]) begin
                        if (m_cnt[i] == 0) m_lhold[i] = int'(m_hold);
                        if (m_cnt[i] <= m_lhold[i]) m_cnt[i]++;
                    end
                    m_rst[i] = (m_cnt[i] <= m_lhold[i]);
                end
                if (req && we) begin
                    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                    case (off)
                        32'h0: begin mrg = (32'(m_clk_en) & ~mask) | (wdata & mask); m_clk_en = mrg[N-1:0]; end
                        32'h4: begin mrg = (32'(m_rst_req) & ~mask) | (wdata & mask); m_rst_req = mrg[N-1:0]; end
                        32'hC: begin mrg = (32'(m_hold) & ~mask) | (wdata & mask); m_hold = mrg[7:0]; end
                        default: ;
                    endcase
                end
                m_ack = req;
            end
        end
    end

    // Monitor: resets every cycle, bus responses whenever ack is seen.
    initial forever begin
        exp_t e;
        @(negedge global_clk);
        if (mon_en) begin
            check("domain_rst", 32'(drst), 32'(m_rst));
            if (ack) begin
                ack_total++;
                $display("[%0t] ack addr=%h we=%0b rdata=%h", $time, addr, we, rdata);
                if (sb.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
                else begin
                    e = sb.pop_front();
                    if (e.is_rd) check("rdata", rdata, e.data);
                end
            end
        end
    end

    initial forever begin
        @(posedge global_clk); #2;
        if (mon_en) check("dclk_high_phase", 32'(dclk), 32'(exp_dclk_hi));
    end
    initial forever begin
        @(negedge global_clk); #2;
        if (mon_en) check("dclk_low_phase", 32'(dclk), 32'd0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wb_access(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s);
        @(negedge global_clk);
        cyc = 1'b1; stb = 1'b1; addr = a; we = w; wdata = d; sel = s;
        @(negedge global_clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask
    task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
        wb_access(BASE + off, 1'b1, d, 4'hF);
    endtask
    task automatic wb_read(input logic [31:0] off);
        wb_access(BASE + off, 1'b0, '0, 4'hF);
    endtask
    task automatic wait_fall(input int b, input int bound);
        int n;
        n = 0;
        while (drst[b] && n < bound) begin @(negedge global_clk); n++; end
    endtask

    initial begin
        longint e_num;
        int     a0;
        bit     dropped;
        logic [31:0] off, d;
        logic [3:0]  s;
        bit          w;

        repeat (3) @(negedge global_clk);
        mon_en = 1;
        @(negedge global_clk);
        global_rst = 1'b0;

        // Reset defaults
        wb_read(32'h0); wb_read(32'h4); wb_read(32'h8);
        wb_read(32'hC); check("t1_hold_default", rdata, 32'h10);

        // Release with hold
        wb_write(32'h0, 32'h3); wb_write(32'hC, 32'd4);
        wb_write(32'h4, 32'hC); e_num = cyc_cnt;
        wait_fall(0, 40);
        check("t2_fall_edge", 32'(cyc_cnt - e_num), 32'd5);
        check("t2_upper_held", 32'(drst), 32'hC);
        wb_write(32'h4, 32'hF); wb_write(32'h4, 32'hC);
        wb_read(32'h8); check("t2_status_hold", 32'(rdata[17:16]), 32'h3);
        wait_fall(1, 40);

        // Gated pause
        wb_write(32'h4, 32'hF); wb_write(32'h0, 32'h1);
        wb_write(32'h4, 32'hE); e_num = cyc_cnt;
        wb_write(32'h0, 32'h0);
        @(negedge global_clk);
        wb_write(32'h0, 32'h1);
        wait_fall(0, 40);
        check("t3_fall_edge", 32'(cyc_cnt - e_num), 32'd8);

        // Abort and re-release
        wb_write(32'h4, 32'hF); wb_write(32'h0, 32'hF); wb_write(32'hC, 32'd10);
        wb_write(32'h4, 32'hB);
        wb_write(32'h4, 32'hF);
        dropped = 0;
        repeat (15) begin @(negedge global_clk); if (!drst[2]) dropped = 1; end
        check("t4_no_drop", 32'(dropped), 32'd0);
        wb_write(32'h4, 32'hB); e_num = cyc_cnt;
        wait_fall(2, 40);
        check("t4_rerelease", 32'(cyc_cnt - e_num), 32'd11);

        // Wishbone edge cases
        @(negedge global_clk);
        a0 = ack_total;
        cyc = 1'b1; stb = 1'b1; addr = BASE + 32'hC; we = 1'b0;
        repeat (6) @(negedge global_clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge global_clk);
        check("t5_stb_hold_acks", 32'(ack_total - a0), 32'd3);
        wb_write(32'hC, 32'h77);
        wb_access(BASE + 32'hC, 1'b1, 32'h0000_5500, 4'b0010);
        wb_read(32'hC); check("t5_sel_byte1", rdata, 32'h77);
        wb_access(BASE + 32'h0, 1'b1, 32'h0000_FF00, 4'b0010);
        wb_read(32'h0);
        @(negedge global_clk);
        a0 = ack_total;
        wb_access(BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF);
        wb_access(BASE + 32'h10, 1'b0, '0, 4'hF);
        wb_access(BASE - 32'h4, 1'b0, '0, 4'hF);
        @(negedge global_clk);
        check("t5_outside_no_ack", 32'(ack_total - a0), 32'd0);
        wb_write(32'h8, 32'hFFFF_FFFF); wb_read(32'h8);
        wb_write(32'h1, 32'hFFFF_FFFF); wb_read(32'h1);

        // Global reset mid-hold
        wb_write(32'h4, 32'hF); wb_write(32'h0, 32'hF); wb_write(32'hC, 32'd20);
        wb_write(32'h4, 32'h0);
        repeat (3) @(negedge global_clk);
        global_rst = 1'b1;
        @(negedge global_clk);
        global_rst = 1'b0;
        check("t6_rst_all", 32'(drst), 32'hF);
        wb_read(32'h0); check("t6_clk_en", rdata, 32'h0);
        wb_read(32'h4); wb_read(32'h8);
        wb_read(32'hC); check("t6_hold", rdata, 32'h10);

        // Randomised traffic
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0: off = 32'h0;
                1: off = 32'h4;
                2: off = 32'h8;
                3: off = 32'hC;
                4: off = 32'($urandom_range(0, 15));
                5: off = 32'h10;
                6: off = 32'hFFFF_FFFC;
                default: off = 32'($urandom_range(0, 3)) * 32'd4;
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (off == 32'hC) d = 32'($urandom_range(0, 5));
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wb_access(BASE + off, w, d, s);
            repeat ($urandom_range(0, 3)) @(negedge global_clk);
        end

        repeat (3) @(negedge global_clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
